// File: rtl/video_timing_pkg.sv
// Shared raster defaults (640x480@60) and test-pattern encodings for the video timing block.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  // Standard 8-bar sequence, white through black.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Test-pattern generator: turns raster counter state into registered RGB, aligned with the
// registered timing outputs of the parent and blanked outside the active area.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  pat_e        pat,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

  logic [9:0]  bar_cnt_q, bar_cnt_d, bar_cnt_cur;
  logic [2:0]  bar_idx_q, bar_idx_d, bar_idx_cur;
  logic [23:0] rgb_q, rgb_d, pix_rgb;
  logic        active;

  always_comb begin
    // Counters restart at the first pixel of each line, so the value in use is forced to 0 there.
    bar_cnt_cur = (hcnt == 10'd0) ? 10'd0 : bar_cnt_q;
    bar_idx_cur = (hcnt == 10'd0) ? 3'd0 : bar_idx_q;
    bar_cnt_d   = bar_cnt_cur + 10'd1;
    bar_idx_d   = bar_idx_cur;
    if (bar_cnt_cur == BAR_LAST) begin
      bar_cnt_d = 10'd0;
      if (bar_idx_cur != 3'd7) bar_idx_d = bar_idx_cur + 3'd1;
    end

    active  = (hcnt < H_ACT) && (vcnt < V_ACT);
    pix_rgb = 24'h000000;
    case (pat)
      PAT_BARS:  pix_rgb = bar_colour(bar_idx_cur);
      PAT_GRID:  pix_rgb = ((hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0) ||
                            (hcnt == H_ACT - 10'd1) || (vcnt == V_ACT - 10'd1)) ? 24'hFFFFFF : 24'h000000;
      PAT_RAMP:  pix_rgb = {3{hcnt[7:0]}};
      PAT_SOLID: pix_rgb = solid_rgb;
      default:   pix_rgb = 24'h000000;
    endcase
    rgb_d = active ? pix_rgb : 24'h000000;
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      rgb_q     <= '0;
    end else if (en) begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      rgb_q     <= rgb_d;
    end
  end

  assign {red, green, blue} = rgb_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, data-enable, coordinates
// and test-pattern RGB, all with one cycle of latency from the counter state.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        line_start,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic       h_act, v_act, origin;
  pat_e       pat_q, pat_d;

  always_comb begin
    h_act  = hcnt_q < H_ACT;
    v_act  = vcnt_q < V_ACT;
    origin = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);

    de_d          = h_act && v_act;
    hsync_d       = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    frame_start_d = origin;
    line_start_d  = (hcnt_q == 10'd0) && v_act;
    x_d           = de_d ? hcnt_q : 10'd0;
    y_d           = de_d ? vcnt_q : 10'd0;

    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end

    // The frame origin both captures the new selection and already renders with it.
    pat_d = origin ? pat_e'(pattern_sel) : pat_q;
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pat_q         <= PAT_BARS;
      de_q          <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else if (en) begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pat_q         <= pat_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  video_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .pixclk    (pixclk),
    .rst       (rst),
    .en        (en),
    .hcnt      (hcnt_q),
    .vcnt      (vcnt_q),
    .pat       (pat_d),
    .solid_rgb (solid_rgb),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a reduced-raster instance for frame-level checks and a default-raster
// instance (active-low hsync) for first-line timing and asynchronous reset.
module tb_video_timing_gen;

  localparam int HA = 20, HF = 2, HS = 3, HB = 3, HT = 28;
  localparam int VA = 36, VF = 2, VS = 2, VB = 2, VT = 42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, en_a = 1'b1;
  logic [1:0]  pattern_sel_a = 2'd0;
  logic [23:0] solid_a = 24'h000000;
  logic        de_a, hsync_a, vsync_a, frame_start_a, line_start_a;
  logic [9:0]  x_a, y_a;
  logic [7:0]  red_a, green_a, blue_a;

  logic        rst_b = 1'b0, en_b = 1'b1;
  logic [1:0]  pattern_sel_b = 2'd0;
  logic [23:0] solid_b = 24'h000000;
  logic        de_b, hsync_b, vsync_b, frame_start_b, line_start_b;
  logic [9:0]  x_b, y_b;
  logic [7:0]  red_b, green_b, blue_b;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_a (
    .pixclk(clk), .rst(rst_a), .en(en_a), .pattern_sel(pattern_sel_a), .solid_rgb(solid_a),
    .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .frame_start(frame_start_a),
    .line_start(line_start_a), .x(x_a), .y(y_a), .red(red_a), .green(green_a), .blue(blue_a)
  );

  video_timing_gen #(
    .HSYNC_POL(1'b0)
  ) dut_b (
    .pixclk(clk), .rst(rst_b), .en(en_b), .pattern_sel(pattern_sel_b), .solid_rgb(solid_b),
    .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .frame_start(frame_start_b),
    .line_start(line_start_b), .x(x_b), .y(y_b), .red(red_b), .green(green_b), .blue(blue_b)
  );

  int checks = 0, errors = 0;
  int h_m = HT - 1, v_m = VT - 1;   // pixel currently shown on dut_a outputs
  int cyc_b = 0;                    // enabled edges of dut_b since reset release
  int tick_count = 0;

  task automatic tick();
    @(posedge clk);
    if (!rst_a && en_a) begin
      if (h_m == HT - 1) begin
        h_m = 0;
        v_m = (v_m == VT - 1) ? 0 : v_m + 1;
      end else begin
        h_m++;
      end
    end
    if (!rst_b) cyc_b++;
    tick_count++;
    #1;
  endtask

  task automatic goto(input int h, input int v);
    tick();
    for (int i = 0; i < HT * VT && !(h_m == h && v_m == v); i++) tick();
  endtask

  task automatic goto_b(input int n);
    for (int i = 0; i < 2000 && cyc_b < n; i++) tick();
  endtask

  task automatic test_reset();
    #2 rst_a = 1'b1; rst_b = 1'b1;
    #1;
    checks++; if (de_a !== 1'b0) begin errors++; $display("FAIL reset_de got %b exp 0", de_a); end
    checks++; if (hsync_a !== 1'b0 || vsync_a !== 1'b0) begin errors++; $display("FAIL reset_sync got h%b v%b exp h0 v0", hsync_a, vsync_a); end
    checks++; if (hsync_b !== 1'b1) begin errors++; $display("FAIL reset_hsync_lowpol got %b exp 1", hsync_b); end
    checks++; if ({x_a, y_a, frame_start_a, line_start_a} !== 22'd0) begin errors++; $display("FAIL reset_xy got x%0d y%0d exp 0", x_a, y_a); end
    checks++; if ({red_a, green_a, blue_a} !== 24'h000000) begin errors++; $display("FAIL reset_rgb got %h exp 000000", {red_a, green_a, blue_a}); end
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    checks++; if (frame_start_a !== 1'b1 || line_start_a !== 1'b1 || de_a !== 1'b1) begin errors++; $display("FAIL first_pixel got fs%b ls%b de%b exp 111", frame_start_a, line_start_a, de_a); end
    checks++; if (x_a !== 10'd0 || y_a !== 10'd0) begin errors++; $display("FAIL first_xy got x%0d y%0d exp 0 0", x_a, y_a); end
    checks++; if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin errors++; $display("FAIL first_rgb got %h exp FFFFFF", {red_a, green_a, blue_a}); end
    checks++; if (frame_start_b !== 1'b1 || de_b !== 1'b1) begin errors++; $display("FAIL first_pixel_b got fs%b de%b exp 11", frame_start_b, de_b); end
    $display("test_reset done");
  endtask

  task automatic test_default_line();
    goto_b(81);
    checks++; if (x_b !== 10'd80 || {red_b, green_b, blue_b} !== 24'hFFFF00) begin errors++; $display("FAIL bar_x80 got x%0d %h exp 80 FFFF00", x_b, {red_b, green_b, blue_b}); end
    goto_b(640);
    checks++; if (x_b !== 10'd639 || de_b !== 1'b1 || {red_b, green_b, blue_b} !== 24'h000000) begin errors++; $display("FAIL bar_x639 got x%0d de%b %h exp 639 1 000000", x_b, de_b, {red_b, green_b, blue_b}); end
    goto_b(641);
    checks++; if (de_b !== 1'b0 || {red_b, green_b, blue_b} !== 24'h000000) begin errors++; $display("FAIL blank_b got de%b %h exp 0 000000", de_b, {red_b, green_b, blue_b}); end
    goto_b(656);
    checks++; if (hsync_b !== 1'b1) begin errors++; $display("FAIL hsync_b_h655 got %b exp 1", hsync_b); end
    goto_b(657);
    checks++; if (hsync_b !== 1'b0) begin errors++; $display("FAIL hsync_b_h656 got %b exp 0", hsync_b); end
    goto_b(752);
    checks++; if (hsync_b !== 1'b0) begin errors++; $display("FAIL hsync_b_h751 got %b exp 0", hsync_b); end
    goto_b(753);
    checks++; if (hsync_b !== 1'b1) begin errors++; $display("FAIL hsync_b_h752 got %b exp 1", hsync_b); end
    goto_b(801);
    checks++; if (line_start_b !== 1'b1 || x_b !== 10'd0 || y_b !== 10'd1) begin errors++; $display("FAIL line1_b got ls%b x%0d y%0d exp 1 0 1", line_start_b, x_b, y_b); end
    goto_b(1501);
    checks++; if (hsync_b !== 1'b0) begin errors++; $display("FAIL hsync_b_line1 got %b exp 0", hsync_b); end
    #2 rst_b = 1'b1;
    #1;
    checks++; if (hsync_b !== 1'b1 || de_b !== 1'b0) begin errors++; $display("FAIL async_rst_b got hs%b de%b exp 1 0", hsync_b, de_b); end
    tick();
    rst_b = 1'b0;
    tick();
    checks++; if (frame_start_b !== 1'b1 || de_b !== 1'b1) begin errors++; $display("FAIL rst_release_b got fs%b de%b exp 1 1", frame_start_b, de_b); end
    $display("test_default_line done");
  endtask

  task automatic test_hsync();
    int hs_cnt, de_cnt;
    goto(0, 1);
    checks++; if (line_start_a !== 1'b1 || y_a !== 10'd1) begin errors++; $display("FAIL line_start got ls%b y%0d exp 1 1", line_start_a, y_a); end
    goto(21, 1);
    checks++; if (hsync_a !== 1'b0 || de_a !== 1'b0) begin errors++; $display("FAIL pre_hsync got hs%b de%b exp 0 0", hsync_a, de_a); end
    tick();
    checks++; if (hsync_a !== 1'b1) begin errors++; $display("FAIL hsync_rise got %b exp 1", hsync_a); end
    goto(24, 1);
    checks++; if (hsync_a !== 1'b1) begin errors++; $display("FAIL hsync_last got %b exp 1", hsync_a); end
    tick();
    checks++; if (hsync_a !== 1'b0) begin errors++; $display("FAIL hsync_fall got %b exp 0", hsync_a); end
    hs_cnt = 0; de_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      tick();
      hs_cnt += int'(hsync_a);
      de_cnt += int'(de_a);
    end
    checks++; if (hs_cnt != HS || de_cnt != HA) begin errors++; $display("FAIL line_counts got hs%0d de%0d exp %0d %0d", hs_cnt, de_cnt, HS, HA); end
    $display("test_hsync done");
  endtask

  task automatic test_frame();
    int de_cnt, vs_cnt, fs_cnt, ls_cnt;
    goto(HT - 1, 37);
    checks++; if (vsync_a !== 1'b0) begin errors++; $display("FAIL pre_vsync got %b exp 0", vsync_a); end
    tick();
    checks++; if (vsync_a !== 1'b1) begin errors++; $display("FAIL vsync_rise got %b exp 1", vsync_a); end
    goto(HT - 1, 39);
    checks++; if (vsync_a !== 1'b1) begin errors++; $display("FAIL vsync_last got %b exp 1", vsync_a); end
    tick();
    checks++; if (vsync_a !== 1'b0) begin errors++; $display("FAIL vsync_fall got %b exp 0", vsync_a); end
    goto(HT - 1, VT - 1);
    de_cnt = 0; vs_cnt = 0; fs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      de_cnt += int'(de_a);
      vs_cnt += int'(vsync_a);
      fs_cnt += int'(frame_start_a);
      ls_cnt += int'(line_start_a);
    end
    checks++; if (de_cnt != HA * VA) begin errors++; $display("FAIL frame_de got %0d exp %0d", de_cnt, HA * VA); end
    checks++; if (vs_cnt != VS * HT) begin errors++; $display("FAIL frame_vsync got %0d exp %0d", vs_cnt, VS * HT); end
    checks++; if (fs_cnt != 1 || ls_cnt != VA) begin errors++; $display("FAIL frame_pulses got fs%0d ls%0d exp 1 %0d", fs_cnt, ls_cnt, VA); end
    $display("test_frame done");
  endtask

  task automatic test_bars();
    goto(1, 2);
    checks++; if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin errors++; $display("FAIL bar0 got %h exp FFFFFF", {red_a, green_a, blue_a}); end
    goto(2, 2);
    checks++; if ({red_a, green_a, blue_a} !== 24'hFFFF00) begin errors++; $display("FAIL bar1 got %h exp FFFF00", {red_a, green_a, blue_a}); end
    goto(8, 2);
    checks++; if ({red_a, green_a, blue_a} !== 24'hFF00FF) begin errors++; $display("FAIL bar4 got %h exp FF00FF", {red_a, green_a, blue_a}); end
    goto(13, 2);
    checks++; if ({red_a, green_a, blue_a} !== 24'h0000FF) begin errors++; $display("FAIL bar6 got %h exp 0000FF", {red_a, green_a, blue_a}); end
    goto(17, 2);
    checks++; if ({red_a, green_a, blue_a} !== 24'h000000 || de_a !== 1'b1) begin errors++; $display("FAIL bar_remainder got %h de%b exp 000000 1", {red_a, green_a, blue_a}, de_a); end
    goto(22, 2);
    checks++; if ({red_a, green_a, blue_a} !== 24'h000000 || x_a !== 10'd0) begin errors++; $display("FAIL bar_blank got %h x%0d exp 000000 0", {red_a, green_a, blue_a}, x_a); end
    $display("test_bars done");
  endtask

  task automatic test_pattern_switch();
    goto(0, 10);
    pattern_sel_a = 2'd2;
    goto(4, 10);
    checks++; if ({red_a, green_a, blue_a} !== 24'h00FFFF) begin errors++; $display("FAIL switch_hold got %h exp 00FFFF", {red_a, green_a, blue_a}); end
    goto(6, 35);
    checks++; if ({red_a, green_a, blue_a} !== 24'h00FF00) begin errors++; $display("FAIL switch_hold_end got %h exp 00FF00", {red_a, green_a, blue_a}); end
    goto(0, 0);
    checks++; if (frame_start_a !== 1'b1 || {red_a, green_a, blue_a} !== 24'h000000) begin errors++; $display("FAIL ramp_x0 got fs%b %h exp 1 000000", frame_start_a, {red_a, green_a, blue_a}); end
    goto(13, 0);
    checks++; if ({red_a, green_a, blue_a} !== 24'h0D0D0D) begin errors++; $display("FAIL ramp_x13 got %h exp 0D0D0D", {red_a, green_a, blue_a}); end
    pattern_sel_a = 2'd1;
    goto(0, 0);
    checks++; if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin errors++; $display("FAIL grid_origin got %h exp FFFFFF", {red_a, green_a, blue_a}); end
    goto(5, 1);
    checks++; if ({red_a, green_a, blue_a} !== 24'h000000) begin errors++; $display("FAIL grid_inner got %h exp 000000", {red_a, green_a, blue_a}); end
    goto(19, 1);
    checks++; if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin errors++; $display("FAIL grid_right got %h exp FFFFFF", {red_a, green_a, blue_a}); end
    goto(5, 32);
    checks++; if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin errors++; $display("FAIL grid_y32 got %h exp FFFFFF", {red_a, green_a, blue_a}); end
    goto(5, 35);
    checks++; if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin errors++; $display("FAIL grid_bottom got %h exp FFFFFF", {red_a, green_a, blue_a}); end
    pattern_sel_a = 2'd3;
    solid_a = 24'h123456;
    goto(5, 5);
    checks++; if ({red_a, green_a, blue_a} !== 24'h123456) begin errors++; $display("FAIL solid got %h exp 123456", {red_a, green_a, blue_a}); end
    goto(21, 5);
    checks++; if ({red_a, green_a, blue_a} !== 24'h000000) begin errors++; $display("FAIL solid_blank got %h exp 000000", {red_a, green_a, blue_a}); end
    $display("test_pattern_switch done");
  endtask

  task automatic test_en_pause();
    int t0;
    goto(0, 0);
    t0 = tick_count;
    goto(10, 4);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (x_a !== 10'd10 || y_a !== 10'd4 || de_a !== 1'b1) begin errors++; $display("FAIL pause_hold got x%0d y%0d de%b exp 10 4 1", x_a, y_a, de_a); end
    end
    en_a = 1'b1;
    tick();
    checks++; if (x_a !== 10'd11 || y_a !== 10'd4) begin errors++; $display("FAIL pause_resume got x%0d y%0d exp 11 4", x_a, y_a); end
    goto(0, 0);
    checks++; if (frame_start_a !== 1'b1 || tick_count - t0 != HT * VT + 5) begin errors++; $display("FAIL pause_period got fs%b %0d exp 1 %0d", frame_start_a, tick_count - t0, HT * VT + 5); end
    $display("test_en_pause done");
  endtask

  task automatic test_async_reset();
    goto(5, 3);
    #2 rst_a = 1'b1;
    h_m = HT - 1; v_m = VT - 1;
    #1;
    checks++; if (de_a !== 1'b0 || x_a !== 10'd0 || y_a !== 10'd0) begin errors++; $display("FAIL async_rst got de%b x%0d y%0d exp 0 0 0", de_a, x_a, y_a); end
    checks++; if ({red_a, green_a, blue_a} !== 24'h000000) begin errors++; $display("FAIL async_rst_rgb got %h exp 000000", {red_a, green_a, blue_a}); end
    tick();
    rst_a = 1'b0;
    tick();
    checks++; if (frame_start_a !== 1'b1 || de_a !== 1'b1 || x_a !== 10'd0) begin errors++; $display("FAIL rst_release got fs%b de%b x%0d exp 1 1 0", frame_start_a, de_a, x_a); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_hsync();
    test_frame();
    test_bars();
    test_pattern_switch();
    test_en_pause();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
